keypad_scan_debounce: RTL and testbench

//  Scans the 4x4 numpad matrix one column at a time, synchronises and debounces the rows,
//  and reports each new press as a one-cycle event {key_valid, key_code, key_alt}.

---
 rtl/keypad_scan_debounce.sv | 159 +++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
// Scans a 4x4 active-low keypad matrix one column at a time and synchronises the rows.
// It debounces whole frames and emits one event per new key press.
// The block also holds the alt-function latch that drives the alt LED.
module keypad_scan_debounce #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] numpad_rows,
    output logic [3:0] numpad_columns,
    input  logic       alt_key,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_alt,
    output logic       key_down,
    output logic       alt_numpad_led
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  STABLE_MAX = CNT_W'(DEBOUNCE_SCANS - 1);
    // Candidate encoding: bit 4 set means "no key", otherwise bits 3:0 are {col,row}.
    localparam logic [4:0]        CAND_NONE  = 5'b10000;

    logic [3:0]        rows_meta;
    logic [3:0]        rows_sync;
    logic              alt_meta;
    logic              alt_sync;
    logic              alt_sync_d;
    logic              alt_rise;
    logic              alt_latched;

    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        col_idx;
    logic [11:0]       frame_lo;
    logic              sample_tick;
    logic              frame_end;
    logic [15:0]       full_frame;

    logic [4:0]        cand;
    logic [4:0]        prev_cand;
    logic [4:0]        reported;
    logic [CNT_W-1:0]  stable_cnt;
    logic [CNT_W-1:0]  next_cnt;
    logic              accept;
    logic              new_press;
    logic              release_ev;

    assign sample_tick    = (slot_cnt == SLOT_LAST);
    assign frame_end      = sample_tick && (col_idx == 2'd3);
    // Column 3 is folded in directly from the synchronised rows in its own sampling cycle.
    assign full_frame     = {~rows_sync, frame_lo};
    assign alt_rise       = alt_sync & ~alt_sync_d;
    assign numpad_columns = ~(4'b0001 << col_idx);
    assign alt_numpad_led = ~alt_latched;

    // Two-flop synchronisers for the asynchronous rows and alt request, plus an alt edge tap.
    always_ff @(posedge clock) begin
        if (reset) begin
            rows_meta  <= 4'hF;
            rows_sync  <= 4'hF;
            alt_meta   <= 1'b0;
            alt_sync   <= 1'b0;
            alt_sync_d <= 1'b0;
        end else begin
            rows_meta  <= numpad_rows;
            rows_sync  <= rows_meta;
            alt_meta   <= alt_key;
            alt_sync   <= alt_meta;
            alt_sync_d <= alt_sync;
        end
    end

    // Slot timer and column stepping; rows are captured only in the last cycle of a slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt <= '0;
            col_idx  <= 2'd0;
            frame_lo <= 12'h000;
        end else if (sample_tick) begin
            slot_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            case (col_idx)
                2'd0:    frame_lo[3:0]  <= ~rows_sync;
                2'd1:    frame_lo[7:4]  <= ~rows_sync;
                2'd2:    frame_lo[11:8] <= ~rows_sync;
                default: frame_lo       <= frame_lo;
            endcase
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Lowest-index pressed key in the completed frame; iterating downward lets the lowest win.
    always_comb begin
        cand = CAND_NONE;
        for (int i = 15; i >= 0; i--) begin
            if (full_frame[i]) begin
                cand = {1'b0, 4'(i)};
            end
        end
    end

    // Stability counter for the candidate, saturating at the acceptance threshold.
    always_comb begin
        next_cnt = '0;
        if (cand == prev_cand) begin
            next_cnt = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + CNT_W'(1);
        end
    end

    assign accept     = frame_end && (next_cnt == STABLE_MAX);
    assign new_press  = accept && !cand[4] && (cand != reported);
    assign release_ev = accept && cand[4];

    // Frame history, reported key and the one-cycle press event.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_cand  <= CAND_NONE;
            stable_cnt <= '0;
            reported   <= CAND_NONE;
            key_down   <= 1'b0;
            key_valid  <= 1'b0;
            key_code   <= 4'h0;
            key_alt    <= 1'b0;
        end else begin
            key_valid <= new_press;
            if (frame_end) begin
                prev_cand  <= cand;
                stable_cnt <= next_cnt;
            end
            if (new_press) begin
                reported <= cand;
                key_down <= 1'b1;
                key_code <= cand[3:0];
                key_alt  <= alt_latched | alt_sync;
            end else if (release_ev) begin
                reported <= CAND_NONE;
                key_down <= 1'b0;
            end
        end
    end

    // Alt latch: set by a rising alt edge, consumed by the next key event; a new edge wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            alt_latched <= 1'b0;
        end else if (alt_rise) begin
            alt_latched <= 1'b1;
        end else if (new_press) begin
            alt_latched <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce with a fast scan (4 cycles per slot) and a 2-frame debounce.
// A matrix model turns the pressed-key vector into row levels from the driven columns.
// Expected events are queued when a press is driven and are checked when key_valid pulses.
module tb_keypad_scan_debounce;

    localparam int FRAME = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] numpad_rows;
    logic [3:0] numpad_columns;
    logic       alt_key = 1'b0;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_alt;
    logic       key_down;
    logic       alt_numpad_led;

    logic [15:0] pressed = 16'h0000;
    logic [4:0]  exp_q[$];
    int n_total   = 0;
    int n_pass    = 0;
    int pulse_cnt = 0;

    keypad_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .numpad_rows    (numpad_rows),
        .numpad_columns (numpad_columns),
        .alt_key        (alt_key),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_alt        (key_alt),
        .key_down       (key_down),
        .alt_numpad_led (alt_numpad_led)
    );

    always #5 clock = ~clock;

    // Matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        numpad_rows = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[c*4+r] && !numpad_columns[c]) numpad_rows[r] = 1'b0;
            end
        end
    end

    // Scoreboard: every key_valid pulse must match the oldest expected event.
    always @(negedge clock) begin
        if (!reset && key_valid === 1'b1) begin
            pulse_cnt++;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL event_unexpected got code=%b alt=%b, no event was expected", key_code, key_alt);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if ({key_code, key_alt} !== e)
                    $display("FAIL event_match got code=%b alt=%b, want code=%b alt=%b",
                             key_code, key_alt, e[4:1], e[0]);
                else
                    n_pass++;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(negedge clock);
    endtask

    task automatic wait_pulse(input int start);
        for (int i = 0; i < 400; i++) begin
            if (pulse_cnt != start) break;
            @(negedge clock);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [3:0] exp_c;
        int start;
        apply_reset();
        n_total++; if (key_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", key_valid); else n_pass++;
        n_total++; if (key_down !== 1'b0) $display("FAIL rst_down got %b want 0", key_down); else n_pass++;
        n_total++; if (key_code !== 4'h0) $display("FAIL rst_code got %b want 0000", key_code); else n_pass++;
        n_total++; if (key_alt !== 1'b0) $display("FAIL rst_alt got %b want 0", key_alt); else n_pass++;
        n_total++; if (alt_numpad_led !== 1'b1) $display("FAIL rst_led got %b want 1", alt_numpad_led); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            exp_c = ~(4'b0001 << (k / 4));
            n_total++;
            if (numpad_columns !== exp_c)
                $display("FAIL col_cycle k=%0d got %b want %b", k, numpad_columns, exp_c);
            else
                n_pass++;
            @(negedge clock);
        end
        start = pulse_cnt;
        wait_frames(19);
        n_total++; if (pulse_cnt !== start) $display("FAIL idle_pulses got %0d want 0", pulse_cnt - start); else n_pass++;
        n_total++; if (key_down !== 1'b0) $display("FAIL idle_down got %b want 0", key_down); else n_pass++;
        n_total++; if (alt_numpad_led !== 1'b1) $display("FAIL idle_led got %b want 1", alt_numpad_led); else n_pass++;
    endtask

    task automatic test_single_press();
        int start = pulse_cnt;
        exp_q.push_back({4'b0100, 1'b0});
        pressed = 16'h0010;
        wait_pulse(start);
        n_total++; if (pulse_cnt !== start + 1) $display("FAIL btn2_pulse got %0d pulses want 1", pulse_cnt - start); else n_pass++;
        n_total++; if (key_down !== 1'b1) $display("FAIL btn2_down got %b want 1", key_down); else n_pass++;
        wait_frames(5);
        n_total++; if (pulse_cnt !== start + 1) $display("FAIL btn2_no_repeat got %0d pulses want 1", pulse_cnt - start); else n_pass++;
        n_total++; if (key_down !== 1'b1) $display("FAIL btn2_held got %b want 1", key_down); else n_pass++;
        pressed = 16'h0000;
        wait_frames(4);
        n_total++; if (key_down !== 1'b0) $display("FAIL btn2_release got %b want 0", key_down); else n_pass++;
        n_total++; if (pulse_cnt !== start + 1) $display("FAIL btn2_release_pulse got %0d pulses want 1", pulse_cnt - start); else n_pass++;
    endtask

    task automatic test_bounce();
        int start = pulse_cnt;
        for (int i = 0; i < 6; i++) begin
            pressed[9] = ~pressed[9];
            wait_frames(1);
        end
        n_total++; if (pulse_cnt !== start) $display("FAIL bounce_quiet got %0d pulses want 0", pulse_cnt - start); else n_pass++;
        n_total++; if (key_down !== 1'b0) $display("FAIL bounce_down got %b want 0", key_down); else n_pass++;
        exp_q.push_back({4'b1001, 1'b0});
        pressed = 16'h0200;
        wait_pulse(start);
        wait_frames(3);
        n_total++; if (pulse_cnt !== start + 1) $display("FAIL bounce_settle got %0d pulses want 1", pulse_cnt - start); else n_pass++;
        pressed = 16'h0000;
        wait_frames(4);
    endtask

    task automatic test_multi_key();
        int start = pulse_cnt;
        exp_q.push_back({4'b0110, 1'b0});
        pressed = 16'h2040;
        wait_pulse(start);
        wait_frames(3);
        n_total++; if (pulse_cnt !== start + 1) $display("FAIL multi_pulse got %0d pulses want 1", pulse_cnt - start); else n_pass++;
        pressed = 16'h0000;
        wait_frames(4);
    endtask

    task automatic test_alt_pulse();
        int start = pulse_cnt;
        alt_key = 1'b1;
        repeat (3) @(negedge clock);
        alt_key = 1'b0;
        repeat (4) @(negedge clock);
        n_total++; if (alt_numpad_led !== 1'b0) $display("FAIL alt_led_on got %b want 0", alt_numpad_led); else n_pass++;
        exp_q.push_back({4'b0000, 1'b1});
        pressed = 16'h0001;
        wait_pulse(start);
        n_total++; if (pulse_cnt !== start + 1) $display("FAIL alt_pulse got %0d pulses want 1", pulse_cnt - start); else n_pass++;
        repeat (2) @(negedge clock);
        n_total++; if (alt_numpad_led !== 1'b1) $display("FAIL alt_led_off got %b want 1", alt_numpad_led); else n_pass++;
        pressed = 16'h0000;
        wait_frames(4);
    endtask

    task automatic test_alt_hold();
        int start = pulse_cnt;
        alt_key = 1'b1;
        repeat (4) @(negedge clock);
        exp_q.push_back({4'b1100, 1'b1});
        pressed = 16'h1000;
        wait_pulse(start);
        n_total++; if (pulse_cnt !== start + 1) $display("FAIL althold_pulse got %0d pulses want 1", pulse_cnt - start); else n_pass++;
        pressed = 16'h0000;
        alt_key = 1'b0;
        wait_frames(4);
        n_total++; if (key_down !== 1'b0) $display("FAIL althold_release got %b want 0", key_down); else n_pass++;
        exp_q.push_back({4'b1100, 1'b0});
        pressed = 16'h1000;
        wait_pulse(start + 1);
        n_total++; if (pulse_cnt !== start + 2) $display("FAIL noalt_pulse got %0d pulses want 2", pulse_cnt - start); else n_pass++;
        n_total++; if (alt_numpad_led !== 1'b1) $display("FAIL noalt_led got %b want 1", alt_numpad_led); else n_pass++;
        pressed = 16'h0000;
        wait_frames(4);
    endtask

    task automatic test_reset_mid();
        int start = pulse_cnt;
        exp_q.push_back({4'b1010, 1'b0});
        pressed = 16'h0400;
        wait_pulse(start);
        n_total++; if (pulse_cnt !== start + 1) $display("FAIL btn9_pulse got %0d pulses want 1", pulse_cnt - start); else n_pass++;
        repeat (6) @(negedge clock);
        apply_reset();
        n_total++; if (numpad_columns !== 4'b1110) $display("FAIL midrst_cols got %b want 1110", numpad_columns); else n_pass++;
        n_total++; if (key_down !== 1'b0) $display("FAIL midrst_down got %b want 0", key_down); else n_pass++;
        exp_q.push_back({4'b1010, 1'b0});
        wait_pulse(start + 1);
        wait_frames(3);
        n_total++; if (pulse_cnt !== start + 2) $display("FAIL btn9_refire got %0d pulses want 2", pulse_cnt - start); else n_pass++;
        n_total++; if (key_down !== 1'b1) $display("FAIL btn9_down got %b want 1", key_down); else n_pass++;
        pressed = 16'h0000;
        wait_frames(4);
        n_total++; if (key_down !== 1'b0) $display("FAIL btn9_release got %b want 0", key_down); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_alt_pulse();
        test_alt_hold();
        test_reset_mid();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL events_missing got %0d outstanding want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
